// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Brief    : I2S serializer for the 16-bit mono mixer output. One free-running
//            9-bit divider produces MCLK (/2), SCLK (/8) and LRCK (/512);
//            the 96 kHz sample stream is decimated to the 48 kHz frame rate
//            and the same word is shifted out on both channels.
//            Optional macro AUDIO_DECIM_AVG_EN: average each pair of incoming
//            samples instead of keeping only the most recent one.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        i2s_mclk,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_dat,
    output logic        frame_strobe,
    output logic        underrun
);

    localparam logic [8:0] C_CNT_LAST  = 9'd511;
    localparam logic [2:0] C_BIT_LAST  = 3'd7;
    localparam logic [4:0] C_SLOT_LSB  = 5'd16;

    logic [8:0]  r_cnt;
    logic [15:0] r_tx_word;
    logic [15:0] r_ready;
    logic        r_fresh;
    logic        r_dat;
    logic        r_frame_strobe;
    logic        r_underrun;

    logic        w_frame_end;
    logic        w_ready_we;
    logic [15:0] w_ready_d;
    logic [4:0]  w_next_slot;
    logic [3:0]  w_bit_idx;
    logic        w_next_bit;

    assign w_frame_end = (r_cnt == C_CNT_LAST);

`ifdef AUDIO_DECIM_AVG_EN
    logic        r_phase;
    logic [15:0] r_acc;

    // Pair average: sign-extend both operands to 17 bits so the sum cannot
    // overflow, then keep bits [16:1] (arithmetic shift right by one).
    assign w_ready_we = sample_valid & r_phase;
    assign w_ready_d  = 16'(({r_acc[15], r_acc} + {sample_in[15], sample_in}) >> 1);

    // Pair phase toggles on every strobe; phase 0 parks the sample in acc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_acc   <= 16'd0;
        end else if (sample_valid) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_acc <= sample_in;
            end
        end
    end
`else
    assign w_ready_we = sample_valid;
    assign w_ready_d  = sample_in;
`endif

    // Bit for the slot that starts on the next clock. Slot 1 carries the MSB,
    // slot 16 the LSB; slot 0 and slots 17..31 are padding zeros.
    assign w_next_slot = r_cnt[7:3] + 5'd1;
    assign w_bit_idx   = 4'(C_SLOT_LSB - w_next_slot);
    assign w_next_bit  = (w_next_slot != 5'd0) && (w_next_slot <= C_SLOT_LSB)
                         ? r_tx_word[w_bit_idx] : 1'b0;

    // Free-running divider; all I2S clocks are taps of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 9'd0;
        end else begin
            r_cnt <= r_cnt + 9'd1;
        end
    end

    // Serial data changes together with the SCLK falling edge, giving the
    // standard one-bit I2S delay relative to LRCK.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat <= 1'b0;
        end else if (r_cnt[2:0] == C_BIT_LAST) begin
            r_dat <= w_next_bit;
        end
    end

    // Sample holding register plus the flag that says it was refreshed since
    // the last frame latch. A write coincident with the latch wins the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 16'd0;
            r_fresh <= 1'b0;
        end else begin
            if (w_ready_we) begin
                r_ready <= w_ready_d;
            end
            if (w_ready_we) begin
                r_fresh <= 1'b1;
            end else if (w_frame_end) begin
                r_fresh <= 1'b0;
            end
        end
    end

    // Frame latch: capture the word for the next frame and report underrun
    // when nothing new arrived; the previous word is simply repeated.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_word      <= 16'd0;
            r_frame_strobe <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_frame_strobe <= w_frame_end;
            r_underrun     <= w_frame_end & ~r_fresh;
            if (w_frame_end) begin
                r_tx_word <= r_ready;
            end
        end
    end

    assign i2s_mclk     = r_cnt[0];
    assign i2s_sclk     = r_cnt[2];
    assign i2s_lrck     = r_cnt[8];
    assign i2s_dat      = r_dat;
    assign frame_strobe = r_frame_strobe;
    assign underrun     = r_underrun;

endmodule
`default_nettype wire
